// File: rtl/tnoc_pkg.sv
// ----------------------------------------------------------------------------
// tnoc_pkg : shared NoC configuration, port count and arbiter state type
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tnoc_pkg;

  localparam int TNOC_PORTS      = 5;
  localparam int TNOC_PORT_WIDTH = $clog2(TNOC_PORTS);

  typedef struct packed {
    int unsigned virtual_channels;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 32'd2};

  typedef enum logic [0:0] {
    TNOC_ARB_IDLE = 1'b0,
    TNOC_ARB_BUSY = 1'b1
  } tnoc_arbiter_state;

endpackage

`default_nettype wire

// File: rtl/tnoc_port_control_if.sv
// ----------------------------------------------------------------------------
// tnoc_port_control_if : per-VC request/grant handshake between route selector and arbiter
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tnoc_port_control_if #(
  parameter int CHANNELS = 2
);

  logic [CHANNELS-1:0] request;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] start_of_packet;
  logic [CHANNELS-1:0] end_of_packet;

  modport requester (
    output request,
    output free,
    output start_of_packet,
    output end_of_packet,
    input  grant
  );

  modport arbiter (
    input  request,
    input  free,
    input  start_of_packet,
    input  end_of_packet,
    output grant
  );

endinterface

`default_nettype wire

// File: rtl/tnoc_round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// tnoc_round_robin_arbiter : combinational pick of the first request at/after i_pointer
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tnoc_round_robin_arbiter #(
  parameter  int REQUESTERS    = 5,
  localparam int POINTER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
)(
  input  logic [REQUESTERS-1:0]    i_request,
  input  logic [POINTER_WIDTH-1:0] i_pointer,
  output logic [REQUESTERS-1:0]    o_grant,
  output logic [POINTER_WIDTH-1:0] o_next_pointer
);

  logic w_found;

  // Pass 0 scans pointer..top, pass 1 wraps around to scan 0..pointer-1.
  always_comb begin
    o_grant        = '0;
    o_next_pointer = i_pointer;
    w_found        = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < REQUESTERS; r++) begin
        if (!w_found && i_request[r] &&
            ((p == 0) == (POINTER_WIDTH'(r) >= i_pointer))) begin
          w_found        = 1'b1;
          o_grant[r]     = 1'b1;
          o_next_pointer = (r == REQUESTERS - 1) ? '0 : POINTER_WIDTH'(r + 1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tnoc_output_port_arbiter.sv
// ----------------------------------------------------------------------------
// tnoc_output_port_arbiter : per-VC packet-locked round-robin owner of one output port
// Optional zero-gap handoff: TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN   Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tnoc_output_port_arbiter
  import tnoc_pkg::*;
#(
  parameter  tnoc_config            CONFIG          = TNOC_DEFAULT_CONFIG,
  parameter  logic [TNOC_PORTS-1:0] AVAILABLE_PORTS = 5'b11111,
  localparam int                    CHANNELS        = int'(CONFIG.virtual_channels)
)(
  input  logic                                clk,
  input  logic                                rst_n,
  tnoc_port_control_if.arbiter                port_control_if [TNOC_PORTS],
  output logic [CHANNELS-1:0][TNOC_PORTS-1:0] o_select,
  output logic [CHANNELS-1:0]                 o_vc_busy
);

  logic [TNOC_PORTS-1:0][CHANNELS-1:0] w_request;
  logic [TNOC_PORTS-1:0][CHANNELS-1:0] w_sop;
  logic [TNOC_PORTS-1:0][CHANNELS-1:0] w_eop;
  logic [TNOC_PORTS-1:0][CHANNELS-1:0] w_free;
  logic [TNOC_PORTS-1:0][CHANNELS-1:0] w_grant;
  logic [CHANNELS-1:0][TNOC_PORTS-1:0] w_candidate;
  logic [CHANNELS-1:0][TNOC_PORTS-1:0] w_end_of_packet;
  logic                                w_unused_free;

  for (genvar r = 0; r < TNOC_PORTS; r++) begin : g_port
    assign w_request[r]             = port_control_if[r].request;
    assign w_sop[r]                 = port_control_if[r].start_of_packet;
    assign w_eop[r]                 = port_control_if[r].end_of_packet;
    assign w_free[r]                = port_control_if[r].free;
    assign port_control_if[r].grant = w_grant[r];
  end

  // Ownership does not depend on downstream credit, so free is not consulted.
  assign w_unused_free = ^w_free;

  always_comb begin
    w_candidate     = '0;
    w_end_of_packet = '0;
    w_grant         = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      for (int r = 0; r < TNOC_PORTS; r++) begin
        w_candidate[v][r]     = w_request[r][v] & w_sop[r][v] & AVAILABLE_PORTS[r];
        w_end_of_packet[v][r] = w_eop[r][v];
        w_grant[r][v]         = o_select[v][r];
      end
    end
  end

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    tnoc_arbiter_state          r_state;
    logic [TNOC_PORTS-1:0]      r_owner;
    logic [TNOC_PORT_WIDTH-1:0] r_pointer;
    logic [TNOC_PORT_WIDTH-1:0] r_owner_next;
    logic [TNOC_PORTS-1:0]      w_arb_request;
    logic [TNOC_PORTS-1:0]      w_arb_grant;
    logic [TNOC_PORT_WIDTH-1:0] w_arb_pointer;
    logic [TNOC_PORT_WIDTH-1:0] w_arb_next;
    logic                       w_release;

`ifdef TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN
    // While busy, arbitrate from just past the owner so a successor is ready at EOP.
    assign w_arb_pointer = (r_state == TNOC_ARB_BUSY) ? r_owner_next : r_pointer;
    assign w_arb_request = w_candidate[v] & ~r_owner;
`else
    assign w_arb_pointer = r_pointer;
    assign w_arb_request = w_candidate[v];
`endif

    assign w_release = |(w_end_of_packet[v] & r_owner);

    tnoc_round_robin_arbiter #(
      .REQUESTERS (TNOC_PORTS)
    ) u_rr (
      .i_request      (w_arb_request),
      .i_pointer      (w_arb_pointer),
      .o_grant        (w_arb_grant),
      .o_next_pointer (w_arb_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state      <= TNOC_ARB_IDLE;
        r_owner      <= '0;
        r_pointer    <= '0;
        r_owner_next <= '0;
      end else begin
        case (r_state)
          TNOC_ARB_IDLE: begin
            if (|w_arb_grant) begin
              r_state      <= TNOC_ARB_BUSY;
              r_owner      <= w_arb_grant;
              r_owner_next <= w_arb_next;
            end
          end
          TNOC_ARB_BUSY: begin
            if (w_release) begin
              r_pointer <= r_owner_next;
`ifdef TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN
              if (|w_arb_grant) begin
                r_owner      <= w_arb_grant;
                r_owner_next <= w_arb_next;
              end else begin
                r_state <= TNOC_ARB_IDLE;
                r_owner <= '0;
              end
`else
              r_state <= TNOC_ARB_IDLE;
              r_owner <= '0;
`endif
            end
          end
          default: begin
            r_state <= TNOC_ARB_IDLE;
            r_owner <= '0;
          end
        endcase
      end
    end

    assign o_select[v]  = r_owner;
    assign o_vc_busy[v] = (r_state == TNOC_ARB_BUSY);
  end

endmodule

`default_nettype wire

// File: tb/tb_tnoc_output_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tnoc_output_port_arbiter : scoreboard bench, full-mask and r4-masked instances
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tnoc_output_port_arbiter;
  import tnoc_pkg::*;

  localparam int CH = int'(TNOC_DEFAULT_CONFIG.virtual_channels);
  localparam int NP = TNOC_PORTS;
  localparam int NB = CH * NP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [CH-1:0] t_req [NP];
  logic [CH-1:0] t_sop [NP];
  logic [CH-1:0] t_eop [NP];

  logic [CH-1:0][NP-1:0] sel_full, sel_mask, gnt_full, gnt_mask;
  logic [CH-1:0]         busy_full, busy_mask;

  tnoc_port_control_if #(.CHANNELS(CH)) pc_full [NP] ();
  tnoc_port_control_if #(.CHANNELS(CH)) pc_mask [NP] ();

  for (genvar r = 0; r < NP; r++) begin : g_src
    assign pc_full[r].request         = t_req[r];
    assign pc_full[r].start_of_packet = t_sop[r];
    assign pc_full[r].end_of_packet   = t_eop[r];
    assign pc_full[r].free            = '0;
    assign pc_mask[r].request         = t_req[r];
    assign pc_mask[r].start_of_packet = t_sop[r];
    assign pc_mask[r].end_of_packet   = t_eop[r];
    assign pc_mask[r].free            = '0;
    for (genvar v = 0; v < CH; v++) begin : g_gnt
      assign gnt_full[v][r] = pc_full[r].grant[v];
      assign gnt_mask[v][r] = pc_mask[r].grant[v];
    end
  end

  tnoc_output_port_arbiter #(.AVAILABLE_PORTS(5'b11111)) u_dut_full (
    .clk             (clk),
    .rst_n           (rst_n),
    .port_control_if (pc_full),
    .o_select        (sel_full),
    .o_vc_busy       (busy_full)
  );

  tnoc_output_port_arbiter #(.AVAILABLE_PORTS(5'b01111)) u_dut_mask (
    .clk             (clk),
    .rst_n           (rst_n),
    .port_control_if (pc_mask),
    .o_select        (sel_mask),
    .o_vc_busy       (busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] full;
    logic [NB-1:0] mask;
  } exp_t;

  exp_t          sb [$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [NP-1:0] masks [2];
  int            m_owner [2][CH];
  int            m_ptr [2][CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int r, input int v, input logic req, input logic sop, input logic eop);
    t_req[r][v] = req;
    t_sop[r][v] = sop;
    t_eop[r][v] = eop;
  endtask

  task automatic clear_all();
    for (int r = 0; r < NP; r++) begin
      t_req[r] = '0;
      t_sop[r] = '0;
      t_eop[r] = '0;
    end
  endtask

  function automatic int pick(int d, int v, int start, int exclude);
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (start + k) % NP;
      if (idx != exclude && t_req[idx][v] && t_sop[idx][v] && masks[d][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < CH; v++) begin
        m_owner[d][v] = -1;
        m_ptr[d][v]   = 0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < CH; v++) begin
        if (m_owner[d][v] < 0) begin
          m_owner[d][v] = pick(d, v, m_ptr[d][v], -1);
        end else if (t_eop[m_owner[d][v]][v]) begin
          int o;
          o             = m_owner[d][v];
          m_ptr[d][v]   = (o + 1) % NP;
          m_owner[d][v] = -1;
`ifdef TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN
          m_owner[d][v] = pick(d, v, m_ptr[d][v], o);
`endif
        end
      end
  endtask

  function automatic logic [NB-1:0] exp_sel(int d);
    logic [CH-1:0][NP-1:0] s;
    s = '0;
    for (int v = 0; v < CH; v++)
      if (m_owner[d][v] >= 0) s[v][m_owner[d][v]] = 1'b1;
    return s;
  endfunction

  function automatic logic [CH-1:0] busy_of(logic [NB-1:0] flat);
    logic [CH-1:0][NP-1:0] s;
    logic [CH-1:0]         b;
    s = flat;
    for (int v = 0; v < CH; v++) b[v] = |s[v];
    return b;
  endfunction

  // Predict the post-edge owners from the inputs now applied, then compare after the edge.
  task automatic step();
    exp_t e;
    if (!rst_n) model_reset();
    else        model_edge();
    e.full = exp_sel(0);
    e.mask = exp_sel(1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sel_full",  32'(sel_full),  32'(e.full));
    check("gnt_full",  32'(gnt_full),  32'(e.full));
    check("busy_full", 32'(busy_full), 32'(busy_of(e.full)));
    check("sel_mask",  32'(sel_mask),  32'(e.mask));
    check("gnt_mask",  32'(gnt_mask),  32'(e.mask));
    check("busy_mask", 32'(busy_mask), 32'(busy_of(e.mask)));
  endtask

  initial begin
    int rr_seen [$];
    int exp_rr [6];
    int obs_rr;
    masks[0] = 5'b11111;
    masks[1] = 5'b01111;
    exp_rr   = '{0, 1, 3, 0, 1, 3};
    model_reset();

    // Reset held with every requester active
    for (int r = 0; r < NP; r++) begin
      t_req[r] = '1;
      t_sop[r] = '1;
      t_eop[r] = '0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy_full", 32'(busy_full), 32'(0));
    clear_all();
    rst_n = 1'b1;
    step();

    // Single requester, 4-flit packet
    drive(2, 0, 1, 1, 0); step();
    check("single_grant_t1", 32'(gnt_full[0][2]), 32'(1));
    step();
    drive(2, 0, 1, 0, 0); step(); step();
    drive(2, 0, 1, 0, 1); step();
    check("single_release", 32'(gnt_full[0][2]), 32'(0));
    clear_all(); step();

    // Round robin of 1-flit packets on VC1
    drive(0, 1, 1, 1, 1); drive(1, 1, 1, 1, 1); drive(3, 1, 1, 1, 1);
    for (int c = 0; c < 14; c++) begin
      step();
      for (int r = 0; r < NP; r++)
        if (sel_full[1][r]) rr_seen.push_back(r);
    end
    check("rr_count", 32'(rr_seen.size() >= 6), 32'(1));
    for (int i = 0; i < 6; i++) begin
      obs_rr = (i < rr_seen.size()) ? rr_seen[i] : -1;
      check("rr_order", 32'(obs_rr), 32'(exp_rr[i]));
    end
    clear_all(); step(); step();

    // Lock: r4 waits behind r1's packet on VC0
    drive(1, 0, 1, 1, 0); step();
    drive(1, 0, 1, 0, 0); drive(4, 0, 1, 1, 0);
    repeat (3) step();
    check("lock_wait", 32'(gnt_full[0][4]), 32'(0));
    drive(1, 0, 1, 0, 1); step();
`ifdef TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN
    check("lock_after_eop", 32'(gnt_full[0][4]), 32'(1));
`else
    check("lock_after_eop", 32'(gnt_full[0][4]), 32'(0));
`endif
    drive(1, 0, 0, 0, 0); step();
    check("lock_granted", 32'(gnt_full[0][4]), 32'(1));
    check("mask_r4_never", 32'(gnt_mask[0][4]), 32'(0));
    drive(4, 0, 1, 0, 1); step();
    clear_all(); step();

    // Masking: r0 served, r4 never served by the masked instance
    drive(0, 0, 1, 1, 0); drive(4, 0, 1, 1, 0); step();
    check("mask_r0_grant", 32'(gnt_mask[0][0]), 32'(1));
    drive(0, 0, 1, 0, 1); step();
    drive(0, 0, 0, 0, 0); repeat (3) step();
    check("mask_r4_held", 32'(gnt_mask[0][4]), 32'(0));
    drive(4, 0, 1, 0, 1); step();
    clear_all(); step();

    // Handoff gap: r0 releases VC0 with r3 waiting
    drive(0, 0, 1, 1, 0); drive(3, 0, 1, 1, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(0, 0, 1, 0, 1); step();
`ifdef TNOC_OUTPUT_PORT_ARBITER_FAST_HANDOFF_EN
    check("handoff_t1", 32'(gnt_full[0][3]), 32'(1));
`else
    check("handoff_t1", 32'(gnt_full[0][3]), 32'(0));
    drive(0, 0, 0, 0, 0); step();
    check("handoff_t2", 32'(gnt_full[0][3]), 32'(1));
`endif
    drive(0, 0, 0, 0, 0); drive(3, 0, 1, 0, 1); step();
    clear_all(); step();

    // Asynchronous reset in the middle of a packet
    drive(2, 1, 1, 1, 0); step();
    drive(2, 1, 1, 0, 0); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel",  32'(sel_full),  32'(0));
    check("arst_busy", 32'(busy_full), 32'(0));
    clear_all();
    drive(1, 1, 1, 1, 0); drive(3, 1, 1, 1, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("arst_ptr_reset", 32'(gnt_full[1][1]), 32'(1));
    drive(1, 1, 1, 0, 1); step();
    clear_all(); step();

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < NP; r++) begin
        t_req[r] = CH'($urandom);
        t_sop[r] = CH'($urandom);
        t_eop[r] = CH'($urandom) & CH'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
